mem_access_initiator: RTL
=========================

// Module: mem_access_initiator
// PURPOSE
// - Initiator side of the byte-addressed RAM port; drives enable/read-write/address/size/data-in and consumes data-out.
// - Sits in the MEM stage of the PA-RISC pipeline.
// - Accepts one load/store request at a time from the pipeline and sequences the RAM access.
// - Sign- or zero-extends load data; flags illegal and misaligned accesses.
// PARAMETERS
// - ADDR_W       8  RAM byte-address width.
// - WAIT_CYCLES  1  Cycles mem_enable is held per access (>=1). Read data is sampled on the last one.
// PORTS
// - clk             in   1       Single clock, rising edge.
// - reset           in   1       Asynchronous, active-high.
// - req_valid       in   1       Request present.
// - req_ready       out  1       Request accepted when req_valid && req_ready at a clk edge.
// - req_write       in   1       0: load, 1: store.
// - req_size        in   2       00: byte, 01: halfword, 10: word, 11: illegal.
// - req_signed      in   1       Loads only: 1 = sign-extend, 0 = zero-extend.
// - req_addr        in   ADDR_W  Byte address (big-endian memory).
// - req_wdata       in   32      Store data, right-justified.
// - resp_valid      out  1       One-cycle completion pulse. No backpressure.
// - resp_rdata      out  32      Extended load data. 0 for stores and faults.
// - resp_fault      out  1       Valid with resp_valid: illegal size, or misaligned (macro on).
// - mem_enable      out  1       To RAM Enable.
// - mem_read_write  out  1       To RAM ReadWrite (0: read, 1: write).
// - mem_address     out  ADDR_W  To RAM Address.
// - mem_size        out  2       To RAM Size.
// - mem_data_in     out  32      To RAM DataIn.
// - mem_data_out    in   32      From RAM DataOut, zero-extended, big-endian assembled.
// BEHAVIOUR
// - Reset (async): state=IDLE. All outputs go to 0 immediately, except req_ready, which is 1 once reset deasserts.
// - FSM states: IDLE, ACCESS, RESP.
// - req_ready = (state==IDLE || state==RESP).
// - IDLE/RESP + accept, legal: latch all mem_* fields, set mem_read_write=req_write, go to ACCESS, counter=WAIT_CYCLES-1.
// - IDLE/RESP + accept, faulting: no memory access; go to RESP next cycle with resp_fault=1 and resp_rdata=0.
// - ACCESS: mem_enable=1. Decrement the counter each cycle. At counter==0:
//   - Load: capture the extended mem_data_out into resp_rdata.
//   - Then go to RESP.
// - RESP: resp_valid=1, mem_enable=0. Without a new accept, go to IDLE.
// - Load latency: accept edge N -> resp_valid in cycle N+WAIT_CYCLES+1.
// - Back-to-back throughput: one access per WAIT_CYCLES+1 cycles.
// - Stability: mem_address, mem_size, mem_data_in and mem_read_write change only at accept edges. They are constant whenever mem_enable=1.
// - mem_enable is low for at least one cycle between consecutive accesses.
// - Store: mem_data_in = req_wdata. The RAM uses the low 8/16/32 bits according to mem_size.
// - Extension:
//   - byte signed -> {{24{d[7]}}, d[7:0]}
//   - half signed -> {{16{d[15]}}, d[15:0]}
//   - word -> unchanged
//   - unsigned -> zero-fill
// - req_size==2'b11: always a fault, with or without the macro.
// - Reset during ACCESS: mem_enable drops asynchronously and the access is aborted. A partially written store is permitted. No resp_valid is produced.
// - The FSM reaches no state outside IDLE/ACCESS/RESP. An unreachable encoding falls back to IDLE.
// CONFIGURATION
// - MISALIGN_TRAP_EN defined:
//   - Misaligned means half with addr[0]!=0, or word with addr[1:0]!=0.
//   - A misaligned request faults per the fault path above; mem_enable never asserts for it.
// - MISALIGN_TRAP_EN undefined:
//   - The address is forced aligned: half clears bit 0, word clears bits 1:0.
//   - The access proceeds and resp_fault is never set for alignment.
// STRUCTURE
// - Package mem_access_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_ILL constants and a state enum (IDLE, ACCESS, RESP).
// - Sub-module load_extend (combinational): inputs data, size, signed; output 32-bit extended data.
// - Top level holds the FSM, wait counter, request latches and the alignment/fault logic.
// TESTING
// - Store word 0xDEADBEEF @0x10, then load word @0x10 unsigned -> resp_rdata=0xDEADBEEF, fault=0, latency WAIT_CYCLES+1.
// - Load byte signed @0x10 -> 0xFFFFFFDE. Load half unsigned @0x12 -> 0x0000BEEF.
// - Store byte 0x7F @0x11, then load word @0x10 -> 0xDE7FBEEF.
// - Load word @0x11:
//   - MISALIGN_TRAP_EN on -> resp_fault=1, rdata=0, mem_enable stays 0.
//   - Off -> rdata=0xDE7FBEEF from 0x10.
// - req_size=2'b11 @0x20 -> resp_fault=1, no mem_enable pulse. Issuing the next request in the RESP cycle is accepted.
// - Assert reset mid-ACCESS of a store -> mem_enable=0 that cycle, no resp_valid; req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared size encodings and FSM state type for the MEM-stage RAM initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

endpackage

// File: rtl/mem_access_initiator_load_extend.sv
// Sign/zero-extends right-justified RAM read data to 32 bits by access size.
// Latency: combinational.
// Backpressure: none.
// Ports: data_i (raw RAM data), size_i (access size), signed_i (1 = sign-extend),
//        ext_o (extended result).
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] ext_o
);

    always_comb begin
        ext_o = data_i;
        case (size_i)
            SIZE_BYTE: ext_o = signed_i ? {{24{data_i[7]}}, data_i[7:0]}
                                        : {24'h0, data_i[7:0]};
            SIZE_HALF: ext_o = signed_i ? {{16{data_i[15]}}, data_i[15:0]}
                                        : {16'h0, data_i[15:0]};
            default:   ext_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_access_initiator.sv
// MEM-stage initiator: sequences one load/store at a time onto a byte-addressed RAM port.
// Latency: accept -> resp_valid after WAIT_CYCLES+1 cycles (1 cycle for faulting requests).
// Backpressure: req_ready only in IDLE/RESP; responses are single-cycle pulses with no backpressure.
// Ports: clk/reset (async active-high); req_* request in; resp_* completion out;
//        mem_* drive the RAM, mem_data_out returns read data.
// Optional feature: define MISALIGN_TRAP_EN to fault misaligned half/word accesses;
//        otherwise the address is forced aligned and the access proceeds.
module mem_access_initiator
    import mem_access_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              mem_enable,
    output logic              mem_read_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_size,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out
);

    localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               mem_enable_q;
    logic               mem_rw_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [1:0]         mem_size_q;
    logic [31:0]        mem_din_q;
    logic               signed_q;
    logic               resp_valid_q;
    logic               resp_fault_q;
    logic [31:0]        resp_rdata_q;

    logic [ADDR_W-1:0]  addr_d;
    logic               fault_d;
    logic [31:0]        ext_rdata;

    // Request decode: address presented to the RAM and whether the request faults.
`ifdef MISALIGN_TRAP_EN
    logic misalign_d;
    assign misalign_d = ((req_size == SIZE_HALF) && req_addr[0]) ||
                        ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
    assign fault_d    = (req_size == SIZE_ILL) || misalign_d;
    assign addr_d     = req_addr;
`else
    assign fault_d = (req_size == SIZE_ILL);
    always_comb begin
        addr_d = req_addr;
        case (req_size)
            SIZE_HALF: addr_d = {req_addr[ADDR_W-1:1], 1'b0};
            SIZE_WORD: addr_d = {req_addr[ADDR_W-1:2], 2'b00};
            default:   addr_d = req_addr;
        endcase
    end
`endif

    load_extend u_load_extend (
        .data_i   (mem_data_out),
        .size_i   (mem_size_q),
        .signed_i (signed_q),
        .ext_o    (ext_rdata)
    );

    // Gated by reset so the pipeline sees no acceptance while reset is held.
    assign req_ready = ~reset && ((state_q == IDLE) || (state_q == RESP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mem_enable_q <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_size_q   <= 2'b00;
            mem_din_q    <= 32'h0;
            signed_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    mem_enable_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    if (req_valid) begin
                        if (fault_d) begin
                            // No RAM access: mem_* keep their previous values.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                        end else begin
                            state_q      <= ACCESS;
                            cnt_q        <= CNT_LAST;
                            mem_enable_q <= 1'b1;
                            mem_rw_q     <= req_write;
                            mem_addr_q   <= addr_d;
                            mem_size_q   <= req_size;
                            mem_din_q    <= req_wdata;
                            signed_q     <= req_signed;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        // Last enabled cycle: read data is sampled here.
                        mem_enable_q <= 1'b0;
                        if (!mem_rw_q) begin
                            resp_rdata_q <= ext_rdata;
                        end
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    mem_enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_fault     = resp_fault_q;
    assign resp_rdata     = resp_rdata_q;
    assign mem_enable     = mem_enable_q;
    assign mem_read_write = mem_rw_q;
    assign mem_address    = mem_addr_q;
    assign mem_size       = mem_size_q;
    assign mem_data_in    = mem_din_q;

endmodule
